// File: rtl/btn_request_ctrl.sv
// ---------------------------------------------------------------------------
// btn_request_ctrl
//   Conditions the raw pedestrian push-button for the traffic-light FSM.
//   Stages: 2-flop synchronizer -> debounce counter -> press detection ->
//   request/ack handshake, plus a 4-bit press counter and a sticky overrun flag.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized cycles the input must differ
//                     from the stable level before that level toggles (>= 2)
//   CNT_W           : debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   btn_raw     in   asynchronous, bouncy button pin (active-high)
//   ack         in   consumer has taken the pending request
//   btn_req     out  request level, set by a press, cleared by ack
//   press_pulse out  one-cycle strobe on each debounced press
//   btn_level   out  debounced button level
//   press_cnt   out  debounced press count, modulo 16
//   overrun     out  sticky: a press arrived while a request was pending
// ---------------------------------------------------------------------------
module btn_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       ack,
  output logic       btn_req,
  output logic       press_pulse,
  output logic       btn_level,
  output logic [3:0] press_cnt,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             req_q, req_d;
  logic             pulse_q;
  logic [3:0]       press_cnt_q, press_cnt_d;
  logic             overrun_q, overrun_d;
  logic             press;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    cnt_d   = cnt_q;
    level_d = level_q;
    press   = 1'b0;

    if (s2_q == level_q) begin
      // Input agrees with the stable level: any partial count is a glitch.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      press   = s2_q;  // only the rising toggle is a press
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A press wins over a simultaneous ack so a new request is never lost.
    if (press)    req_d = 1'b1;
    else if (ack) req_d = 1'b0;
    else          req_d = req_q;

    press_cnt_d = press ? press_cnt_q + 4'd1 : press_cnt_q;
    overrun_d   = overrun_q | (press & req_q & ~ack);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    if (reset) begin
      // NOTE: synchronizer flops are reset too, so a button held through
      // reset is seen as a fresh 0->1 transition and debounced again.
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      req_q       <= 1'b0;
      pulse_q     <= 1'b0;
      press_cnt_q <= 4'd0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= btn_raw;
      s2_q        <= s1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      req_q       <= req_d;
      pulse_q     <= press;
      press_cnt_q <= press_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign btn_req     = req_q;
  assign press_pulse = pulse_q;
  assign btn_level   = level_q;
  assign press_cnt   = press_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_btn_request_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_request_ctrl
//   Self-checking bench for btn_request_ctrl with DEBOUNCE_CYCLES = 4.
//   A behavioural model (input delay line + run-length of disagreement)
//   is stepped alongside the DUT and compared after every edge; a hand
//   derived vector table and directed sequences cover the corner cases.
// ---------------------------------------------------------------------------
module tb_btn_request_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic       ack = 1'b0;
  logic       btn_req, press_pulse, btn_level, overrun;
  logic [3:0] press_cnt;

  int checks = 0;
  int errors = 0;

  btn_request_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .ack        (ack),
    .btn_req    (btn_req),
    .press_pulse(press_pulse),
    .btn_level  (btn_level),
    .press_cnt  (press_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // pipe[0] is the newest sampled pin value, pipe[1] the one used downstream.
  bit pipe [2];
  int m_run;     // consecutive cycles the delayed input disagreed with level
  bit m_level, m_req, m_pulse, m_ovr;
  int m_cnt;

  function automatic void model_step(input bit r, input bit raw, input bit a);
    bit p;
    bit old_req;
    if (r) begin
      pipe[0] = 0; pipe[1] = 0; m_run = 0;
      m_level = 0; m_req = 0; m_pulse = 0; m_ovr = 0; m_cnt = 0;
      return;
    end
    p = 0;
    old_req = m_req;
    if (pipe[1] != m_level) begin
      m_run++;
      if (m_run == N) begin
        m_level = pipe[1];
        m_run = 0;
        p = m_level;
      end
    end else begin
      m_run = 0;
    end
    if (p) m_req = 1;
    else if (a) m_req = 0;
    if (p && old_req && !a) m_ovr = 1;
    if (p) m_cnt = (m_cnt + 1) % 16;
    m_pulse = p;
    pipe[1] = pipe[0];
    pipe[0] = raw;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive, edge, advance model, compare away from the edge.
  task automatic tick(input bit r, input bit raw, input bit a);
    reset = r; btn_raw = raw; ack = a;
    @(posedge clk);
    model_step(r, raw, a);
    #1;
    check("model_btn_req",     btn_req,     m_req);
    check("model_press_pulse", press_pulse, m_pulse);
    check("model_btn_level",   btn_level,   m_level);
    check("model_press_cnt",   press_cnt,   m_cnt);
    check("model_overrun",     overrun,     m_ovr);
  endtask

  task automatic wait_req(input bit raw, input bit target, input int budget, input string name);
    int n = 0;
    while (btn_req !== target && n < budget) begin
      tick(0, raw, 0);
      n++;
    end
    check(name, btn_req, target);
  endtask

  task automatic wait_level(input bit raw, input bit target, input int budget, input string name);
    int n = 0;
    while (btn_level !== target && n < budget) begin
      tick(0, raw, 0);
      n++;
    end
    check(name, btn_level, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       rst, raw, a;
    bit       req, pulse, level;
    int       cnt;
    bit       ovr;
  } vec_t;

  function automatic vec_t mk(bit rst, bit raw, bit a, bit req, bit pulse, bit level, int cnt, bit ovr);
    vec_t v;
    v.rst = rst; v.raw = raw; v.a = a;
    v.req = req; v.pulse = pulse; v.level = level; v.cnt = cnt; v.ovr = ovr;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    bit pat [6];
    int pulses, pulse_idx;
    bit raw_v, ack_v, rst_v;
    int run_left;

    // Reset held with the button pressed, then a clean press/ack/release.
    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 1, 1, 1, 0);   // edge 6: press detected
    tbl[8]  = mk(0, 1, 0, 1, 0, 1, 1, 0);   // pulse lasts one cycle
    tbl[9]  = mk(0, 1, 1, 0, 0, 1, 1, 0);   // ack clears request
    for (int i = 10; i <= 14; i++) tbl[i] = mk(0, 0, 0, 0, 0, 1, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 0);   // release edge 6: no pulse

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rst, tbl[i].raw, tbl[i].a);
      check($sformatf("tbl%0d_req", i),   btn_req,     tbl[i].req);
      check($sformatf("tbl%0d_pulse", i), press_pulse, tbl[i].pulse);
      check($sformatf("tbl%0d_level", i), btn_level,   tbl[i].level);
      check($sformatf("tbl%0d_cnt", i),   press_cnt,   tbl[i].cnt);
      check($sformatf("tbl%0d_ovr", i),   overrun,     tbl[i].ovr);
    end

    // Bounce: 1,0,1,1,0,1 then steady 1; steady run starts at index 5.
    tick(1, 0, 0);
    tick(0, 0, 0);
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    pulses = 0;
    pulse_idx = -1;
    for (int i = 0; i < 20; i++) begin
      tick(0, (i < 6) ? pat[i] : 1'b1, 0);
      if (press_pulse) begin
        pulses++;
        pulse_idx = i;
      end
      if (i == 9) check("bounce_level_low", btn_level, 0);
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_pulse_edge", pulse_idx, 10);
    check("bounce_cnt", press_cnt, 1);

    // Handshake.
    tick(1, 0, 0);
    tick(0, 0, 0);
    wait_req(1, 1, 12, "hs_req_rise");
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(0, 1, 1);
    check("hs_ack_clear", btn_req, 0);
    wait_level(0, 0, 12, "hs_release1");
    wait_req(1, 1, 12, "hs_req2");
    check("hs_ovr_stays0", overrun, 0);
    wait_level(0, 0, 12, "hs_release2");
    wait_level(1, 1, 12, "hs_press3");
    check("hs_ovr_set", overrun, 1);
    tick(0, 1, 1);
    check("hs_ack3_clear", btn_req, 0);
    check("hs_ovr_sticky", overrun, 1);

    // Press with ack on the very edge of a new press, request already pending.
    wait_level(0, 0, 12, "sim_release1");
    wait_level(1, 1, 12, "sim_press_pending");
    check("sim_req_pending", btn_req, 1);
    wait_level(0, 0, 12, "sim_release2");
    for (int i = 0; i < 5; i++) tick(0, 1, 0);
    tick(0, 1, 1);
    check("sim_pulse", press_pulse, 1);
    check("sim_req_kept", btn_req, 1);
    check("sim_ovr", overrun, 1);

    // Wrap: 17 presses each acknowledged.
    tick(1, 0, 0);
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < N + 2; i++) tick(0, 1, 0);
      check($sformatf("wrap_cnt%0d", p), press_cnt, (p + 1) % 16);
      tick(0, 1, 1);
      for (int i = 0; i < N + 2; i++) tick(0, 0, 0);
    end
    check("wrap_final_cnt", press_cnt, 1);
    check("wrap_ovr", overrun, 0);

    // Randomized runs against the model.
    tick(1, 0, 0);
    raw_v = 0;
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        raw_v = ~raw_v;
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      ack_v = ($urandom_range(0, 3) == 0);
      rst_v = ($urandom_range(0, 499) == 0);
      tick(rst_v, raw_v, ack_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
